mbc_rtc_sequencer: RTL and testbench

MBC_RTC_SEQUENCER -- requirements
Module: mbc_rtc_sequencer

---
 rtl/mbc_rtc_sequencer_pkg.sv | 44 ++++
 rtl/mbc_rtc_sequencer_if.sv | 38 +++
 rtl/mbc_rtc_ld_filter.sv | 73 +++++++
 rtl/mbc_rtc_sequencer.sv | 146 ++++++++++++++
 tb/tb_mbc_rtc_sequencer.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mbc_rtc_sequencer_pkg.sv
//------------------------------------------------------------------------------
// Module : mbc_rtc_sequencer_pkg
// Brief  : Shared FSM state type, save word indices and commit marker for the
//          MBC RTC save/load sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mbc_rtc_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SNAP  = 3'd1,
        ST_CHECK = 3'd2,
        ST_SEND  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [2:0]  c_WORD_TS_LO  = 3'd0;
    localparam logic [2:0]  c_WORD_TS_HI  = 3'd1;
    localparam logic [2:0]  c_WORD_ST_LO  = 3'd2;
    localparam logic [2:0]  c_WORD_ST_HI  = 3'd3;
    localparam logic [2:0]  c_WORD_COMMIT = 3'd4;
    localparam logic [15:0] c_COMMIT_WORD = 16'h0001;

    // Payload of one save word, selected from the captured snapshot.
    function automatic logic [15:0] word_data(input logic [2:0]  idx,
                                              input logic [31:0] ts,
                                              input logic [31:0] st);
        logic [15:0] w;
        case (idx)
            c_WORD_TS_LO:  w = ts[15:0];
            c_WORD_TS_HI:  w = ts[31:16];
            c_WORD_ST_LO:  w = st[15:0];
            c_WORD_ST_HI:  w = st[31:16];
            c_WORD_COMMIT: w = c_COMMIT_WORD;
            default:       w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mbc_rtc_sequencer_if.sv
//------------------------------------------------------------------------------
// Module : mbc_rtc_sequencer_if
// Brief  : Save stream, load stream and backup-write bundle of the sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mbc_rtc_sequencer_if;
    logic        save_req;
    logic        save_valid;
    logic        save_ready;
    logic [2:0]  save_addr;
    logic [15:0] save_data;
    logic        save_done;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic        bk_rtc_wr;
    logic [7:0]  bk_addr;
    logic [15:0] bk_data;
    logic        ld_err;
    logic        busy;

    modport master (
        output save_req, save_ready, ld_valid, ld_addr, ld_data,
        input  save_valid, save_addr, save_data, save_done, ld_ready,
               bk_rtc_wr, bk_addr, bk_data, ld_err, busy
    );

    modport slave (
        input  save_req, save_ready, ld_valid, ld_addr, ld_data,
        output save_valid, save_addr, save_data, save_done, ld_ready,
               bk_rtc_wr, bk_addr, bk_data, ld_err, busy
    );
endinterface

`default_nettype wire

// File: rtl/mbc_rtc_ld_filter.sv
//------------------------------------------------------------------------------
// Module : mbc_rtc_ld_filter
// Brief  : Load-path receive mask; forwards RTC words and gates the commit word.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mbc_rtc_ld_filter
    import mbc_rtc_sequencer_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        i_enable,
    input  wire logic        i_accept,
    input  wire logic [2:0]  i_addr,
    input  wire logic [15:0] i_data,
    output logic             o_wr,
    output logic [7:0]       o_addr,
    output logic [15:0]      o_data,
    output logic             o_err
);

    logic [3:0]  r_mask;
    logic        r_wr;
    logic        r_err;
    logic [7:0]  r_addr;
    logic [15:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= 4'h0;
            r_wr   <= 1'b0;
            r_err  <= 1'b0;
            r_addr <= 8'h00;
            r_data <= 16'h0000;
        end else if (!i_enable) begin
            r_mask <= 4'h0;
            r_wr   <= 1'b0;
            r_err  <= 1'b0;
            r_addr <= 8'h00;
            r_data <= 16'h0000;
        end else begin
            r_wr  <= 1'b0;
            r_err <= 1'b0;
            if (i_accept) begin
                if (i_addr < c_WORD_COMMIT) begin
                    r_mask[i_addr[1:0]] <= 1'b1;
                    r_wr   <= 1'b1;
                    r_addr <= {5'd0, i_addr};
                    r_data <= i_data;
                end else if (i_addr == c_WORD_COMMIT) begin
                    // Commit only lands after a complete word set.
                    r_mask <= 4'h0;
                    if (r_mask == 4'hF) begin
                        r_wr   <= 1'b1;
                        r_addr <= {5'd0, i_addr};
                        r_data <= i_data;
                    end else begin
                        r_err  <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_wr   = r_wr;
    assign o_err  = r_err;
    assign o_addr = r_addr;
    assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/mbc_rtc_sequencer.sv
//------------------------------------------------------------------------------
// Module : mbc_rtc_sequencer
// Brief  : Captures a coherent RTC snapshot and streams it as save words;
//          forwards restored RTC words to the backup registers.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mbc_rtc_sequencer
    import mbc_rtc_sequencer_pkg::*;
#(
    parameter int RETRY_MAX = 4
) (
    input  wire logic        clk_sys,
    input  wire logic        reset_n,
    input  wire logic        enable,
    input  wire logic        rtc_inuse,
    input  wire logic [31:0] rtc_timestamp,
    input  wire logic [47:0] rtc_savedtime,
    mbc_rtc_sequencer_if.slave bus
);

    localparam int c_RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

    state_t                 r_state;
    logic                   r_pending;
    logic [c_RETRY_W-1:0]   r_retry;
    logic [31:0]            r_snap_ts;
    logic [31:0]            r_snap_st;
    logic                   r_save_valid;
    logic [2:0]             r_save_addr;
    logic [15:0]            r_save_data;
    logic                   r_save_done;

    logic                   w_live_match;
    logic                   w_ld_ready;
    logic                   w_unused_st_hi;

    assign w_unused_st_hi = ^rtc_savedtime[47:32];
    assign w_live_match   = (rtc_timestamp == r_snap_ts) &&
                            (rtc_savedtime[31:0] == r_snap_st);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_pending    <= 1'b0;
            r_retry      <= '0;
            r_snap_ts    <= 32'h0;
            r_snap_st    <= 32'h0;
            r_save_valid <= 1'b0;
            r_save_addr  <= 3'd0;
            r_save_data  <= 16'h0;
            r_save_done  <= 1'b0;
        end else if (!enable) begin
            r_state      <= ST_IDLE;
            r_pending    <= 1'b0;
            r_retry      <= '0;
            r_save_valid <= 1'b0;
            r_save_addr  <= 3'd0;
            r_save_data  <= 16'h0;
            r_save_done  <= 1'b0;
        end else begin
            r_save_done <= 1'b0;
            if (bus.save_req && (r_state != ST_IDLE)) begin
                r_pending <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (bus.save_req || r_pending) begin
                        r_state   <= ST_SNAP;
                        r_pending <= 1'b0;
                        r_retry   <= '0;
                    end
                end
                ST_SNAP: begin
                    r_snap_ts <= rtc_timestamp;
                    r_snap_st <= rtc_savedtime[31:0];
                    if (!rtc_inuse) begin
                        r_state     <= ST_DONE;
                        r_save_done <= 1'b1;
                    end else begin
                        r_state     <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    // A tick landed between captures: re-sample until stable or out of retries.
                    if (w_live_match || (r_retry == c_RETRY_W'(RETRY_MAX))) begin
                        r_state      <= ST_SEND;
                        r_save_valid <= 1'b1;
                        r_save_addr  <= c_WORD_TS_LO;
                        r_save_data  <= word_data(c_WORD_TS_LO, r_snap_ts, r_snap_st);
                    end else begin
                        r_retry   <= r_retry + c_RETRY_W'(1);
                        r_snap_ts <= rtc_timestamp;
                        r_snap_st <= rtc_savedtime[31:0];
                    end
                end
                ST_SEND: begin
                    if (bus.save_ready) begin
                        if (r_save_addr == c_WORD_COMMIT) begin
                            r_state      <= ST_DONE;
                            r_save_valid <= 1'b0;
                            r_save_addr  <= 3'd0;
                            r_save_data  <= 16'h0;
                            r_save_done  <= 1'b1;
                        end else begin
                            r_save_addr  <= r_save_addr + 3'd1;
                            r_save_data  <= word_data(r_save_addr + 3'd1, r_snap_ts, r_snap_st);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_ld_ready     = (r_state == ST_IDLE) & enable & reset_n;

    assign bus.ld_ready   = w_ld_ready;
    assign bus.save_valid = r_save_valid;
    assign bus.save_addr  = r_save_addr;
    assign bus.save_data  = r_save_data;
    assign bus.save_done  = r_save_done;
    assign bus.busy       = enable & ((r_state != ST_IDLE) | r_pending);

    mbc_rtc_ld_filter u_ld_filter (
        .clk      (clk_sys),
        .rst_n    (reset_n),
        .i_enable (enable),
        .i_accept (bus.ld_valid & w_ld_ready),
        .i_addr   (bus.ld_addr),
        .i_data   (bus.ld_data),
        .o_wr     (bus.bk_rtc_wr),
        .o_addr   (bus.bk_addr),
        .o_data   (bus.bk_data),
        .o_err    (bus.ld_err)
    );

endmodule

`default_nettype wire

// File: tb/tb_mbc_rtc_sequencer.sv
//------------------------------------------------------------------------------
// Module : tb_mbc_rtc_sequencer
// Brief  : Scoreboard bench for the RTC save/load sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mbc_rtc_sequencer;

    typedef struct packed { logic [2:0] a; logic [15:0] d; } sw_t;
    typedef struct { logic [7:0] a; logic [15:0] d; int cyc; } bk_t;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        rtc_inuse = 1'b0;
    logic [31:0] ts = 32'h0;
    logic [47:0] st = 48'h0;

    mbc_rtc_sequencer_if bus();

    mbc_rtc_sequencer #(.RETRY_MAX(4)) u_dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .enable        (enable),
        .rtc_inuse     (rtc_inuse),
        .rtc_timestamp (ts),
        .rtc_savedtime (st),
        .bus           (bus.slave)
    );

    always #5 clk_sys = ~clk_sys;

    sw_t        save_q[$];
    bk_t        bk_q[$];
    int         err_q[$];
    logic [3:0] m_mask = 4'h0;
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, done_cnt = 0, last_done = -1, valid_cnt = 0, last_rise = -1;
    int bk_cnt = 0, err_cnt = 0;
    logic       prev_valid = 1'b0, hold = 1'b0;
    logic [2:0] held_a = 3'd0;
    logic [15:0] held_d = 16'h0;

    // One clock: observe at negedge, then return 1 time unit after the posedge.
    task automatic tick();
        sw_t e;
        bk_t b;
        @(negedge clk_sys);
        cyc++;
        if (bus.save_valid) begin
            valid_cnt++;
            if (!prev_valid) last_rise = cyc;
            if (hold) begin
                n_cmp++;
                if ({bus.save_addr, bus.save_data} !== {held_a, held_d}) begin
                    n_bad++;
                    $display("FAIL save_hold: got %0d/%h want %0d/%h", bus.save_addr, bus.save_data, held_a, held_d);
                end
            end
            if (bus.save_ready) begin
                n_cmp++;
                if (save_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL save_word: got unexpected %0d/%h", bus.save_addr, bus.save_data);
                end else begin
                    e = save_q.pop_front();
                    if (bus.save_addr !== e.a || bus.save_data !== e.d) begin
                        n_bad++;
                        $display("FAIL save_word: got %0d/%h want %0d/%h", bus.save_addr, bus.save_data, e.a, e.d);
                    end
                end
            end
        end
        hold       = bus.save_valid & ~bus.save_ready;
        held_a     = bus.save_addr;
        held_d     = bus.save_data;
        prev_valid = bus.save_valid;
        if (bus.save_done) begin
            done_cnt++;
            last_done = cyc;
        end
        if (bus.bk_rtc_wr) begin
            bk_cnt++;
            n_cmp++;
            if (bk_q.size() == 0) begin
                n_bad++;
                $display("FAIL bk_write: got unexpected %h/%h", bus.bk_addr, bus.bk_data);
            end else begin
                b = bk_q.pop_front();
                if (bus.bk_addr !== b.a || bus.bk_data !== b.d || cyc != b.cyc) begin
                    n_bad++;
                    $display("FAIL bk_write: got %h/%h @%0d want %h/%h @%0d", bus.bk_addr, bus.bk_data, cyc, b.a, b.d, b.cyc);
                end
            end
        end
        if (bus.ld_err) begin
            err_cnt++;
            n_cmp++;
            if (err_q.size() == 0 || err_q[0] != cyc) begin
                n_bad++;
                $display("FAIL ld_err: got pulse @%0d want %0d", cyc, (err_q.size() == 0) ? -1 : err_q[0]);
            end
            if (err_q.size() != 0) void'(err_q.pop_front());
        end
        // Expected load-path results from the receive-mask rules.
        if (bus.ld_valid && bus.ld_ready) begin
            if (bus.ld_addr < 3'd4) begin
                m_mask[bus.ld_addr[1:0]] = 1'b1;
                bk_q.push_back('{{5'd0, bus.ld_addr}, bus.ld_data, cyc + 1});
            end else if (bus.ld_addr == 3'd4) begin
                if (m_mask == 4'hF) bk_q.push_back('{8'd4, bus.ld_data, cyc + 1});
                else err_q.push_back(cyc + 1);
                m_mask = 4'h0;
            end
        end
        @(posedge clk_sys);
        #1;
    endtask

    task automatic push_save(input logic [31:0] t, input logic [31:0] s);
        save_q.push_back({3'd0, t[15:0]});
        save_q.push_back({3'd1, t[31:16]});
        save_q.push_back({3'd2, s[15:0]});
        save_q.push_back({3'd3, s[31:16]});
        save_q.push_back({3'd4, 16'h0001});
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        enable  = 1'b1;
        tick();
        n_cmp++;
        if ({bus.save_valid, bus.save_done, bus.bk_rtc_wr, bus.ld_err, bus.busy, bus.ld_ready} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 000000", {bus.save_valid, bus.save_done, bus.bk_rtc_wr, bus.ld_err, bus.busy, bus.ld_ready});
        end
        n_cmp++;
        if ({bus.save_addr, bus.save_data, bus.bk_addr, bus.bk_data} !== 43'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", {bus.save_addr, bus.save_data, bus.bk_addr, bus.bk_data});
        end
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if (bus.ld_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_ld_ready: got %b want 1", bus.ld_ready);
        end
    endtask

    task automatic test_basic_save();
        int d0, rc;
        rtc_inuse = 1'b1;
        ts = 32'h1234_5678;
        st = 48'h0000_0ABC_DEF0;
        bus.save_ready = 1'b1;
        push_save(ts, st[31:0]);
        d0 = done_cnt;
        rc = cyc + 1;
        bus.save_req = 1'b1;
        tick();
        bus.save_req = 1'b0;
        for (int i = 0; i < 40 && done_cnt == d0; i++) tick();
        n_cmp++;
        if (done_cnt != d0 + 1) begin n_bad++; $display("FAIL basic_done: got %0d want %0d", done_cnt - d0, 1); end
        n_cmp++;
        if (last_rise != rc + 3) begin n_bad++; $display("FAIL basic_latency: got %0d want %0d", last_rise - rc, 3); end
        n_cmp++;
        if (save_q.size() != 0) begin n_bad++; $display("FAIL basic_words: got %0d left want 0", save_q.size()); end
        tick();
        n_cmp++;
        if ({bus.busy, bus.ld_ready} !== 2'b01) begin n_bad++; $display("FAIL basic_idle: got %b want 01", {bus.busy, bus.ld_ready}); end
    endtask

    task automatic test_retry();
        int d0, rc;
        logic [31:0] a5;
        a5 = 32'hA000_0005;
        push_save(a5, st[31:0]);
        d0 = done_cnt;
        rc = cyc + 1;
        ts = 32'hA000_0000;
        bus.save_req = 1'b1;
        tick();
        bus.save_req = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            ts = 32'hA000_0000 + 32'(k);
            tick();
        end
        for (int i = 0; i < 40 && done_cnt == d0; i++) tick();
        n_cmp++;
        if (done_cnt != d0 + 1) begin n_bad++; $display("FAIL retry_done: got %0d want 1", done_cnt - d0); end
        n_cmp++;
        if (last_rise != rc + 7) begin n_bad++; $display("FAIL retry_latency: got %0d want 7", last_rise - rc); end
        tick();
    endtask

    task automatic send_loads(input int n, input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                              input logic [2:0] a3, input logic [2:0] a4);
        logic [2:0] as [5];
        as = '{a0, a1, a2, a3, a4};
        for (int k = 0; k < n; k++) begin
            bus.ld_valid = 1'b1;
            bus.ld_addr  = as[k];
            bus.ld_data  = 16'hC000 + 16'(k) + {13'd0, as[k]} * 16'h0100;
            tick();
        end
        bus.ld_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick();
    endtask

    task automatic test_load_full();
        int b0, e0;
        b0 = bk_cnt; e0 = err_cnt;
        send_loads(5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4);
        n_cmp++;
        if (bk_cnt - b0 != 5 || err_cnt != e0) begin
            n_bad++; $display("FAIL load_full: got %0d wr %0d err want 5 wr 0 err", bk_cnt - b0, err_cnt - e0);
        end
    endtask

    task automatic test_load_gap();
        int b0, e0;
        b0 = bk_cnt; e0 = err_cnt;
        send_loads(3, 3'd0, 3'd2, 3'd4, 3'd0, 3'd0);
        n_cmp++;
        if (bk_cnt - b0 != 2 || err_cnt - e0 != 1) begin
            n_bad++; $display("FAIL load_gap: got %0d wr %0d err want 2 wr 1 err", bk_cnt - b0, err_cnt - e0);
        end
    endtask

    task automatic test_load_drop();
        int b0, e0;
        b0 = bk_cnt; e0 = err_cnt;
        send_loads(5, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7);
        n_cmp++;
        if (bk_cnt - b0 != 1 || err_cnt - e0 != 1) begin
            n_bad++; $display("FAIL load_drop: got %0d wr %0d err want 1 wr 1 err", bk_cnt - b0, err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        int d0, b0;
        d0 = done_cnt; b0 = bk_cnt;
        bus.save_ready = 1'b1;
        push_save(ts, st[31:0]);
        bus.ld_valid = 1'b1; bus.ld_addr = 3'd1; bus.ld_data = 16'hB2B2;
        bus.save_req = 1'b1;
        tick();
        bus.ld_valid = 1'b0; bus.save_req = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.ld_ready} !== 2'b10) begin n_bad++; $display("FAIL b2b_snap: got %b want 10", {bus.busy, bus.ld_ready}); end
        for (int i = 0; i < 40 && done_cnt == d0; i++) tick();
        tick();
        n_cmp++;
        if (done_cnt != d0 + 1 || bk_cnt - b0 != 1) begin
            n_bad++; $display("FAIL b2b_result: got %0d done %0d wr want 1 done 1 wr", done_cnt - d0, bk_cnt - b0);
        end
    endtask

    task automatic test_pending();
        int d0;
        d0 = done_cnt;
        ts = 32'h5555_AAAA;
        st = 48'hFFFF_0102_0304;
        push_save(ts, st[31:0]);
        push_save(ts, st[31:0]);
        bus.save_req = 1'b1;
        tick();
        bus.save_req = 1'b0;
        for (int i = 0; i < 100 && done_cnt < d0 + 2; i++) begin
            bus.save_ready = i[0];
            bus.save_req   = (i == 6 || i == 9);
            tick();
        end
        bus.save_req = 1'b0;
        bus.save_ready = 1'b1;
        for (int k = 0; k < 12; k++) tick();
        n_cmp++;
        if (done_cnt != d0 + 2 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL pending_collapse: got %0d done busy=%b want 2 done busy=0", done_cnt - d0, bus.busy);
        end
    endtask

    task automatic test_no_rtc();
        int d0, v0, rc;
        rtc_inuse = 1'b0;
        d0 = done_cnt; v0 = valid_cnt; rc = cyc + 1;
        bus.save_req = 1'b1;
        tick();
        bus.save_req = 1'b0;
        for (int i = 0; i < 20 && done_cnt == d0; i++) tick();
        n_cmp++;
        if (done_cnt != d0 + 1 || last_done != rc + 2) begin
            n_bad++; $display("FAIL no_rtc_done: got %0d done after %0d want 1 done after 2", done_cnt - d0, last_done - rc);
        end
        n_cmp++;
        if (valid_cnt != v0) begin n_bad++; $display("FAIL no_rtc_valid: got %0d valid cycles want 0", valid_cnt - v0); end
        rtc_inuse = 1'b1;
        tick();
    endtask

    task automatic test_enable_off();
        int d0;
        d0 = done_cnt;
        bus.save_ready = 1'b0;
        push_save(ts, st[31:0]);
        bus.save_req = 1'b1;
        tick();
        bus.save_req = 1'b0;
        for (int i = 0; i < 10 && !bus.save_valid; i++) tick();
        enable = 1'b0;
        tick();
        save_q.delete();
        m_mask = 4'h0;
        n_cmp++;
        if ({bus.save_valid, bus.busy, bus.ld_ready, bus.save_done} !== 4'b0) begin
            n_bad++; $display("FAIL enable_off: got %b want 0000", {bus.save_valid, bus.busy, bus.ld_ready, bus.save_done});
        end
        enable = 1'b1;
        bus.save_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        n_cmp++;
        if (done_cnt != d0 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL enable_resume: got %0d done busy=%b want 0 done busy=0", done_cnt - d0, bus.busy);
        end
    endtask

    task automatic test_reset_mid_send();
        int d0;
        d0 = done_cnt;
        bus.save_ready = 1'b1;
        push_save(ts, st[31:0]);
        bus.save_req = 1'b1;
        tick();
        bus.save_req = 1'b0;
        for (int i = 0; i < 10 && !bus.save_valid; i++) tick();
        reset_n = 1'b0;
        #1;
        save_q.delete();
        m_mask = 4'h0;
        n_cmp++;
        if ({bus.save_valid, bus.save_done, bus.busy} !== 3'b0) begin
            n_bad++; $display("FAIL reset_abort: got %b want 000", {bus.save_valid, bus.save_done, bus.busy});
        end
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        n_cmp++;
        if (done_cnt != d0) begin n_bad++; $display("FAIL reset_no_done: got %0d done want 0", done_cnt - d0); end
    endtask

    initial begin
        bus.save_req = 1'b0; bus.save_ready = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_addr = 3'd0; bus.ld_data = 16'h0;
        test_reset();
        test_basic_save();
        test_retry();
        test_load_full();
        test_load_gap();
        test_load_drop();
        test_back_to_back();
        test_pending();
        test_no_rtc();
        test_enable_off();
        test_reset_mid_send();
        n_cmp++;
        if (save_q.size() != 0 || bk_q.size() != 0 || err_q.size() != 0) begin
            n_bad++; $display("FAIL leftover: got %0d/%0d/%0d want 0/0/0", save_q.size(), bk_q.size(), err_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
